// File: rtl/gf180mcu_fd_sc_mcu7t5v0__syncdeb_2.sv
// Synchronizing debounce conditioner: a SYNC_STAGES-deep synchronizer followed by a stability-window filter.
// Define GF180MCU_FD_SC_MCU7T5V0_SYNCDEB_EDGE_EN to add registered RISE/FALL edge pulses.
module gf180mcu_fd_sc_mcu7t5v0__syncdeb_2 #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_COUNT   = 8,
  parameter int CNT_W       = 4
) (
  input  logic CLK,
  input  logic RN,
  input  logic I,
  input  logic EN,
`ifdef GF180MCU_FD_SC_MCU7T5V0_SYNCDEB_EDGE_EN
  output logic RISE,
  output logic FALL,
`endif
  output logic Z,
  output logic ZN
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEB_COUNT < 1) begin : g_bad_deb
    $error("DEB_COUNT must be at least 1");
  end
  if ((2 ** CNT_W) < DEB_COUNT) begin : g_bad_cnt_w
    $error("CNT_W too narrow for DEB_COUNT");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_COUNT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   z_q, z_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], I};
    z_d    = z_q;
    cnt_d  = '0;
    // cnt only ever reaches CNT_LAST before Z flips, so it cannot wrap
    if (EN && (s != z_q)) begin
      if (cnt_q == CNT_LAST) begin
        z_d = s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync_q <= '0;
      cnt_q  <= '0;
      z_q    <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      z_q    <= z_d;
    end
  end

  assign Z  = z_q;
  assign ZN = ~z_q;

`ifdef GF180MCU_FD_SC_MCU7T5V0_SYNCDEB_EDGE_EN
  logic rise_q, rise_d, fall_q, fall_d;

  always_comb begin
    rise_d = ~z_q & z_d;
    fall_d = z_q & ~z_d;
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign RISE = rise_q;
  assign FALL = fall_q;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__syncdeb_2.sv
// Bench for the syncdeb conditioner: default instance (DEB_COUNT=8) and boundary instance (DEB_COUNT=1, CNT_W=1).
module tb_gf180mcu_fd_sc_mcu7t5v0__syncdeb_2;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rn, i_in, en;
  logic z0, zn0, z1, zn1;
`ifdef GF180MCU_FD_SC_MCU7T5V0_SYNCDEB_EDGE_EN
  logic rise0, fall0, rise1, fall1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__syncdeb_2 #(.SYNC_STAGES(SS), .DEB_COUNT(8), .CNT_W(4)) dut0 (
    .CLK(clk), .RN(rn), .I(i_in), .EN(en),
`ifdef GF180MCU_FD_SC_MCU7T5V0_SYNCDEB_EDGE_EN
    .RISE(rise0), .FALL(fall0),
`endif
    .Z(z0), .ZN(zn0));

  gf180mcu_fd_sc_mcu7t5v0__syncdeb_2 #(.SYNC_STAGES(SS), .DEB_COUNT(1), .CNT_W(1)) dut1 (
    .CLK(clk), .RN(rn), .I(i_in), .EN(en),
`ifdef GF180MCU_FD_SC_MCU7T5V0_SYNCDEB_EDGE_EN
    .RISE(rise1), .FALL(fall1),
`endif
    .Z(z1), .ZN(zn1));

  // Reference: history of I seen at each edge since reset; the filter sees the value from SS edges ago,
  // and Z flips once it has disagreed with that delayed input for deb[d] consecutive enabled edges.
  logic hist[$];
  int   deb[2] = '{8, 1};
  int   run[2];
  logic mz[2], er[2], ef[2];

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int d = 0; d < 2; d++) begin
      run[d] = 0; mz[d] = 1'b0; er[d] = 1'b0; ef[d] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check("z0", z0, mz[0]);
    check("zn0", zn0, ~mz[0]);
    check("z1", z1, mz[1]);
    check("zn1", zn1, ~mz[1]);
`ifdef GF180MCU_FD_SC_MCU7T5V0_SYNCDEB_EDGE_EN
    check("rise0", rise0, er[0]);
    check("fall0", fall0, ef[0]);
    check("rise1", rise1, er[1]);
    check("fall1", fall1, ef[1]);
    check("no_overlap0", rise0 & fall0, 1'b0);
    check("no_overlap1", rise1 & fall1, 1'b0);
`endif
  endtask

  // One clock edge: advance the model with the current inputs, then compare 1 time unit after the edge.
  task automatic step();
    logic s;
    int n;
    hist.push_back(i_in);
    n = hist.size();
    s = (n > SS) ? hist[n-1-SS] : 1'b0;
    for (int d = 0; d < 2; d++) begin
      er[d] = 1'b0; ef[d] = 1'b0;
      if (!en || s == mz[d]) begin
        run[d] = 0;
      end else begin
        run[d]++;
        if (run[d] == deb[d]) begin
          er[d] = s; ef[d] = ~s;
          mz[d] = s;
          run[d] = 0;
        end
      end
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  initial begin
    int len;
    rn = 1'b0; i_in = 1'b0; en = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();

    // release, I high from before edge 1: Z rises exactly on edge 10
    rn = 1'b1; i_in = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      check("lat_edge10", z0, (e >= 10) ? 1'b1 : 1'b0);
    end

    // asynchronous reset mid-cycle, no clock edge needed
    #3 rn = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("async_z", z0, 1'b0);
    @(posedge clk); #1;
    rn = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      step();
      check("relat_edge10", z0, (e >= 10) ? 1'b1 : 1'b0);
    end

    // glitches: low for 9 then back high, low for 5 then back high
    i_in = 1'b0;
    repeat (9) step();
    i_in = 1'b1;
    repeat (12) step();
    i_in = 1'b0;
    repeat (5) step();
    i_in = 1'b1;
    repeat (10) step();
    check("glitch5_hold", z0, 1'b1);

    // enable gating: mismatch for 4 edges, EN low 3 edges, then 8 more needed
    i_in = 1'b0;
    repeat (SS + 4) step();
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      step();
      check("en_restart", z0, (e >= 8) ? 1'b0 : 1'b1);
    end

    // boundary instance: toggle every 3 cycles
    for (int k = 0; k < 30; k++) begin
      if (k % 3 == 0) i_in = ~i_in;
      step();
    end

    // random held levels with sparse enable drops
    for (int seg = 0; seg < 60; seg++) begin
      i_in = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        en = ($urandom_range(0, 9) != 0);
        step();
      end
    end
    en = 1'b1;
    repeat (12) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__syncdeb_2.md
# gf180mcu_fd_sc_mcu7t5v0__syncdeb_2

Synchronizing debounce conditioner that sits directly upstream of the library inverter. It takes an asynchronous, possibly glitchy level (pad or off-domain signal) and produces a clean, clock-aligned level `Z` and its complement `ZN`, so the following inverter stage sees no metastable or short-pulse input. The block has a fixed synchronizer depth, a programmable stability window, and an optional edge-pulse feature.

## Interface
- `SYNC_STAGES`, 2 — flip-flop depth of the synchronizer chain; legal range ≥ 2.
- `DEB_COUNT`, 8 — consecutive cycles of disagreement required before `Z` changes; legal range ≥ 1.
- `CNT_W`, 4 — width of the debounce counter; must satisfy 2^CNT_W ≥ DEB_COUNT. Violation is an elaboration error.

- `CLK`  input  1  — single clock; all state updates on the rising edge.
- `RN`  input  1  — reset; asynchronous, active-low.
- `I`  input  1  — asynchronous raw input level.
- `EN`  input  1  — debounce enable; synchronous.
- `Z`  output  1  — debounced, synchronized level.
- `ZN`  output  1  — complement of `Z`.
- `RISE`  output  1  — one-cycle pulse on a 0→1 change of `Z`. Present only with the configuration macro.
- `FALL`  output  1  — one-cycle pulse on a 1→0 change of `Z`. Present only with the configuration macro.

## Operation
- **Synchronizer.** This is a chain of `SYNC_STAGES` flops. It always shifts `I` in, regardless of `EN`. `s` is the last stage. No logic sits between stages.
- **Debounce state.** The block holds `Z` (register) and `cnt` (`CNT_W` bits).
- **Per rising edge with `EN`=1:**
  - If `s == Z`: `cnt` ← 0.
  - Else if `cnt == DEB_COUNT-1`: `Z` ← `s` and `cnt` ← 0.
  - Else: `cnt` ← `cnt` + 1.
- **`EN`=0.** `Z` holds and `cnt` ← 0. Re-enabling restarts the stability window from zero.
- **`ZN`.** Combinational `~Z`. It has no additional state.
- **Glitch rejection.** Any excursion of `s` that lasts fewer than `DEB_COUNT` consecutive cycles returns `cnt` to 0 and leaves `Z` unchanged.
- **Counter range.** `cnt` never exceeds `DEB_COUNT-1`, so it cannot wrap.
- **`DEB_COUNT`=1.** `Z` follows `s` one cycle later.

## Timing
- **Reset (`RN`=0).** Takes effect immediately, without waiting for a clock:
  - all synchronizer stages = 0
  - `Z`=0, `ZN`=1, `cnt`=0
  - `RISE`=0, `FALL`=0
- **Reset release.** Deassertion is synchronous to `CLK` at the system level. The first update occurs on the first rising edge with `RN`=1.
- **Reset mid-window.** All progress is discarded. After release, the full latency applies again.
- **Latency.** If `I` changes and stays stable from before edge 1, with `EN`=1 throughout:
  - `s` reflects the new value after edge `SYNC_STAGES`.
  - `Z` changes on edge `SYNC_STAGES+DEB_COUNT`. With defaults this is edge 10.
- **`I` returns mid-window.** If `I` returns to the old value before `Z` changes, `cnt` clears on the first edge where `s == Z`.
- **`EN` deasserted mid-window.** `cnt` clears on that edge and `Z` is unchanged. Counting resumes from 0 on the first edge with `EN`=1.

## Configuration
- **Macro:** `GF180MCU_FD_SC_MCU7T5V0_SYNCDEB_EDGE_EN`.
- **Defined.**
  - `RISE` and `FALL` ports and their registers exist.
  - On the edge where `Z` changes 0→1, `RISE` ← 1. On every other edge, `RISE` ← 0. `FALL` is symmetric for 1→0.
  - Each pulse is high for exactly one cycle and is aligned with the new value of `Z`.
  - `RISE` and `FALL` are never high together.
- **Undefined.** The ports and logic are absent. `Z` and `ZN` behaviour is identical to the defined case.

## Test plan
- **Reset:** drive `RN`=0 mid-cycle with `I`=1 → `Z`=0, `ZN`=1 and `RISE`=`FALL`=0 without a clock edge. After release with `I`=1 held and `EN`=1, `Z` rises on edge 10.
- **Clean rise (defaults):** `I` 0→1 before edge 1 → `Z`=0 through edge 9 and `Z`=1 from edge 10. With the macro, `RISE` is high for only the cycle after edge 10.
- **Glitch rejection:** `I` high for 9 cycles then low, `DEB_COUNT`=8 → `s` high for 9 cycles and `Z` rises on the 8th. A separate 5-cycle pulse → `Z` stays 0 and `cnt` returns to 0.
- **Enable gating:** with `I`=1, drop `EN` after 4 mismatch cycles for 3 cycles, then restore → `Z` rises 8 edges after `EN` returns, not earlier.
- **Boundary `DEB_COUNT`=1, `CNT_W`=1:** toggle `I` every 3 cycles → `Z` tracks `I` delayed by `SYNC_STAGES`+1 edges. With the macro, `RISE` and `FALL` alternate and never overlap.
